// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared opcodes, ALU-op encodings and control bundles for the pipelined control unit
// Contents: opcode constants, alu_op_e, ctrl_t (ID decode bundle), ex_ctrl_t (ID/EX bundle), NOP constants
package pipe_ctrl_pkg;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10
   } alu_op_e;
   typedef struct packed {
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    mem_to_reg;
      logic    reg_dst;
      logic    alu_src;
      logic    branch;
      logic    bne;
      logic    jump;
      alu_op_e alu_op;
   } ctrl_t;
   localparam int CTRL_W = $bits(ctrl_t);
   localparam ctrl_t CTRL_NOP = '{alu_op: ALU_ADD, default: 1'b0};
   // jump never travels past ID, so the ID/EX bundle carries no jump bit
   typedef struct packed {
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    mem_to_reg;
      logic    reg_dst;
      logic    alu_src;
      logic    branch;
      logic    bne;
      alu_op_e alu_op;
   } ex_ctrl_t;
   localparam ex_ctrl_t EX_NOP = '{alu_op: ALU_ADD, default: 1'b0};
endpackage

// File: rtl/pipe_ctrl_unit_decoder.sv
// ctrl_decoder: combinational opcode to control-bundle decoder
// Ports: opcode_i (ID opcode) -> ctrl_o (control bundle, all-zero for unknown opcodes)
module ctrl_decoder
   import pipe_ctrl_pkg::*;
#(
   parameter int OPCODE_W = 6
) (
   input  logic [OPCODE_W-1:0] opcode_i,
   output ctrl_t               ctrl_o
);
   always_comb begin
      case (opcode_i)
         OP_R:    ctrl_o = '{reg_write: 1'b1, reg_dst: 1'b1, alu_op: ALU_FUNCT, default: 1'b0};
         OP_LW:   ctrl_o = '{reg_write: 1'b1, mem_read: 1'b1, mem_to_reg: 1'b1, alu_src: 1'b1, alu_op: ALU_ADD, default: 1'b0};
         OP_SW:   ctrl_o = '{mem_write: 1'b1, alu_src: 1'b1, alu_op: ALU_ADD, default: 1'b0};
         OP_ADDI: ctrl_o = '{reg_write: 1'b1, alu_src: 1'b1, alu_op: ALU_ADD, default: 1'b0};
         OP_BEQ:  ctrl_o = '{branch: 1'b1, alu_op: ALU_SUB, default: 1'b0};
         OP_BNE:  ctrl_o = '{branch: 1'b1, bne: 1'b1, alu_op: ALU_SUB, default: 1'b0};
         OP_J:    ctrl_o = '{jump: 1'b1, alu_op: ALU_ADD, default: 1'b0};
         default: ctrl_o = CTRL_NOP;
      endcase
   end
endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipelined control unit with load-use stall and branch/jump flush for a 5-stage MIPS core
// Inputs: clk_i, rst_n_i (sync, active-low), hold_i (freeze), ID fields id_opcode_i/id_rs_i/id_rt_i/id_rd_i, ex_branch_taken_i
// Outputs: pc_write_o, if_id_write_o, if_id_flush_o, id_jump_o, EX controls, MEM controls, WB controls and wb_dest_o
module pipe_ctrl_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W   = 5,
   parameter int OPCODE_W     = 6,
   parameter int STALL_CYCLES = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  hold_i,
   input  logic [OPCODE_W-1:0]   id_opcode_i,
   input  logic [REG_ADDR_W-1:0] id_rs_i,
   input  logic [REG_ADDR_W-1:0] id_rt_i,
   input  logic [REG_ADDR_W-1:0] id_rd_i,
   input  logic                  ex_branch_taken_i,
   output logic                  pc_write_o,
   output logic                  if_id_write_o,
   output logic                  if_id_flush_o,
   output logic                  id_jump_o,
   output logic                  ex_regDst_o,
   output logic                  ex_ALUSrc_o,
   output logic [1:0]            ex_alu_op_o,
   output logic                  ex_branch_o,
   output logic                  ex_bne_o,
   output logic                  mem_memRead_o,
   output logic                  mem_memWrite_o,
   output logic                  wb_regWrite_o,
   output logic                  wb_memToReg_o,
   output logic [REG_ADDR_W-1:0] wb_dest_o
);
   localparam int CNT_W = $clog2(STALL_CYCLES + 1);
   ctrl_t                 id_ctrl;
   logic [REG_ADDR_W-1:0] id_dest;
   logic                  uses_rt, hazard, taken, stall, bubble;
   ex_ctrl_t              ex_d, ex_q;
   logic [REG_ADDR_W-1:0] ex_dest_d, ex_dest_q, mem_dest_q, wb_dest_q;
   logic [CNT_W-1:0]      stall_cnt_d, stall_cnt_q;
   logic                  mem_reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;
   logic                  wb_reg_write_q, wb_mem_to_reg_q;
   ctrl_decoder #(.OPCODE_W(OPCODE_W)) u_dec (
      .opcode_i (id_opcode_i),
      .ctrl_o   (id_ctrl)
   );
   always_comb begin
      id_dest = id_ctrl.reg_dst ? id_rd_i : id_rt_i;
      // R, SW, BEQ and BNE are exactly the opcodes that read rt as a source
      uses_rt = id_ctrl.reg_dst | id_ctrl.mem_write | id_ctrl.branch;
      hazard  = ex_q.mem_read && (ex_dest_q != '0) &&
                ((ex_dest_q == id_rs_i) || (uses_rt && (ex_dest_q == id_rt_i)));
      taken   = ex_q.branch && (ex_branch_taken_i ^ ex_q.bne);
      stall   = !taken && (hazard || (stall_cnt_q != '0));
      bubble  = taken || stall || id_ctrl.jump;
      ex_d    = bubble ? EX_NOP : ex_ctrl_t'{
                   reg_write:  id_ctrl.reg_write && (id_dest != '0),
                   mem_read:   id_ctrl.mem_read,
                   mem_write:  id_ctrl.mem_write,
                   mem_to_reg: id_ctrl.mem_to_reg,
                   reg_dst:    id_ctrl.reg_dst,
                   alu_src:    id_ctrl.alu_src,
                   branch:     id_ctrl.branch,
                   bne:        id_ctrl.bne,
                   alu_op:     id_ctrl.alu_op};
      ex_dest_d   = bubble ? '0 : id_dest;
      stall_cnt_d = taken ? '0 :
                    hazard ? CNT_W'(STALL_CYCLES - 1) :
                    (stall_cnt_q != '0) ? stall_cnt_q - CNT_W'(1) : stall_cnt_q;
   end
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         ex_q            <= EX_NOP;
         ex_dest_q       <= '0;
         stall_cnt_q     <= '0;
         mem_reg_write_q <= 1'b0;
         mem_read_q      <= 1'b0;
         mem_write_q     <= 1'b0;
         mem_to_reg_q    <= 1'b0;
         mem_dest_q      <= '0;
         wb_reg_write_q  <= 1'b0;
         wb_mem_to_reg_q <= 1'b0;
         wb_dest_q       <= '0;
      end else if (!hold_i) begin
         ex_q            <= ex_d;
         ex_dest_q       <= ex_dest_d;
         stall_cnt_q     <= stall_cnt_d;
         mem_reg_write_q <= ex_q.reg_write;
         mem_read_q      <= ex_q.mem_read;
         mem_write_q     <= ex_q.mem_write;
         mem_to_reg_q    <= ex_q.mem_to_reg;
         mem_dest_q      <= ex_dest_q;
         wb_reg_write_q  <= mem_reg_write_q;
         wb_mem_to_reg_q <= mem_to_reg_q;
         wb_dest_q       <= mem_dest_q;
      end
   end
   assign pc_write_o     = !hold_i && !stall;
   assign if_id_write_o  = !hold_i && !stall;
   // a jump stuck behind a stall must survive in IF/ID, so only an advancing jump flushes
   assign if_id_flush_o  = !hold_i && (taken || (id_ctrl.jump && !stall));
   assign id_jump_o      = id_ctrl.jump;
   assign ex_regDst_o    = ex_q.reg_dst;
   assign ex_ALUSrc_o    = ex_q.alu_src;
   assign ex_alu_op_o    = ex_q.alu_op;
   assign ex_branch_o    = ex_q.branch;
   assign ex_bne_o       = ex_q.bne;
   assign mem_memRead_o  = mem_read_q;
   assign mem_memWrite_o = mem_write_q;
   assign wb_regWrite_o  = wb_reg_write_q;
   assign wb_memToReg_o  = wb_mem_to_reg_q;
   assign wb_dest_o      = wb_dest_q;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: checks pipe_ctrl_unit (STALL_CYCLES=1 and 2) against a behavioural pipeline model
module tb_pipe_ctrl_unit;
   localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, ADDI = 6'b001000;
   localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, J = 6'b000010, UND = 6'b111111;
   typedef struct packed {
      logic       rw, mr, mw, mtr, rdst, asrc, br, bne;
      logic [1:0] aop;
      logic [4:0] dest;
   } st_t;
   logic       clk = 1'b0;
   logic       rst_n, hold, bt;
   logic [5:0] op;
   logic [4:0] rs, rt, rd;
   logic       pcw[2], ifw[2], flu[2], jmp[2], rdst[2], asrc[2], br[2], bne[2], mr[2], mw[2], wrw[2], wmtr[2];
   logic [1:0] aop[2];
   logic [4:0] wdst[2];
   st_t        m_ex[2], m_mem[2], m_wb[2];
   int         tick[2], stall_until[2];
   logic       m_hz[2], m_tk[2], m_st[2];
   int         n_chk = 0, n_err = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 2; g++) begin : g_dut
      pipe_ctrl_unit #(.REG_ADDR_W(5), .OPCODE_W(6), .STALL_CYCLES(g + 1)) dut (
         .clk_i             (clk),
         .rst_n_i           (rst_n),
         .hold_i            (hold),
         .id_opcode_i       (op),
         .id_rs_i           (rs),
         .id_rt_i           (rt),
         .id_rd_i           (rd),
         .ex_branch_taken_i (bt),
         .pc_write_o        (pcw[g]),
         .if_id_write_o     (ifw[g]),
         .if_id_flush_o     (flu[g]),
         .id_jump_o         (jmp[g]),
         .ex_regDst_o       (rdst[g]),
         .ex_ALUSrc_o       (asrc[g]),
         .ex_alu_op_o       (aop[g]),
         .ex_branch_o       (br[g]),
         .ex_bne_o          (bne[g]),
         .mem_memRead_o     (mr[g]),
         .mem_memWrite_o    (mw[g]),
         .wb_regWrite_o     (wrw[g]),
         .wb_memToReg_o     (wmtr[g]),
         .wb_dest_o         (wdst[g])
      );
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic st_t decode(input logic [5:0] o, input logic [4:0] s_rt, input logic [4:0] s_rd);
      st_t r = '0;
      case (o)
         R:    begin r.rw = 1; r.rdst = 1; r.aop = 2'b10; end
         LW:   begin r.rw = 1; r.mr = 1; r.mtr = 1; r.asrc = 1; end
         SW:   begin r.mw = 1; r.asrc = 1; end
         ADDI: begin r.rw = 1; r.asrc = 1; end
         BEQ:  begin r.br = 1; r.aop = 2'b01; end
         BNE:  begin r.br = 1; r.bne = 1; r.aop = 2'b01; end
         default: r = '0;
      endcase
      r.dest = r.rdst ? s_rd : s_rt;
      if (r.dest == 5'd0) r.rw = 1'b0;
      return r;
   endfunction
   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_ex[i] = '0; m_mem[i] = '0; m_wb[i] = '0;
         tick[i] = 0; stall_until[i] = -1;
      end
   endtask
   task automatic step(input logic [5:0] o, input logic [4:0] s, input logic [4:0] tt, input logic [4:0] d,
                       input logic b, input logic h, input logic r);
      logic is_j, urt;
      op = o; rs = s; rt = tt; rd = d; bt = b; hold = h; rst_n = r;
      is_j = (o == J);
      urt  = (o == R) || (o == BEQ) || (o == BNE) || (o == SW);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         st_t   e = m_ex[i];
         string p = $sformatf("S%0d_", i + 1);
         m_hz[i] = e.mr && (e.dest != 0) && ((e.dest == s) || (urt && (e.dest == tt)));
         m_tk[i] = e.br && (b ^ e.bne);
         m_st[i] = !m_tk[i] && (m_hz[i] || (tick[i] <= stall_until[i]));
         check({p, "ctl"}, {pcw[i], ifw[i], flu[i], jmp[i]},
               {!h && !m_st[i], !h && !m_st[i], !h && (m_tk[i] || (is_j && !m_st[i])), is_j});
         check({p, "ex"}, {rdst[i], asrc[i], aop[i], br[i], bne[i]}, {e.rdst, e.asrc, e.aop, e.br, e.bne});
         check({p, "mem"}, {mr[i], mw[i]}, {m_mem[i].mr, m_mem[i].mw});
         check({p, "wb"}, {wrw[i], wmtr[i], wdst[i]}, {m_wb[i].rw, m_wb[i].mtr, m_wb[i].dest});
      end
      @(posedge clk);
      if (!r) model_reset();
      else if (!h) begin
         for (int i = 0; i < 2; i++) begin
            if (m_tk[i]) stall_until[i] = -1;
            else if (m_hz[i]) stall_until[i] = tick[i] + i;
            tick[i]++;
            m_wb[i]  = m_mem[i];
            m_mem[i] = m_ex[i];
            m_ex[i]  = (m_tk[i] || m_st[i] || is_j) ? st_t'('0) : decode(o, tt, d);
         end
      end
      #1;
   endtask
   task automatic nops(input int n);
      for (int k = 0; k < n; k++) step(UND, 0, 0, 0, 0, 0, 1);
   endtask
   initial begin
      op = UND; rs = 0; rt = 0; rd = 0; bt = 0; hold = 0; rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      step(R, 1, 1, 3, 0, 0, 1); nops(4);
      step(LW, 0, 2, 0, 0, 0, 1); repeat (3) step(R, 2, 1, 4, 0, 0, 1); nops(4);
      step(LW, 0, 0, 0, 0, 0, 1); step(R, 0, 1, 5, 0, 0, 1); nops(3);
      step(BEQ, 1, 1, 0, 0, 0, 1); step(R, 1, 1, 6, 1, 0, 1); nops(3);
      step(BNE, 1, 1, 0, 0, 0, 1); step(R, 1, 1, 6, 1, 0, 1); nops(3);
      step(LW, 0, 2, 0, 0, 0, 1); step(R, 2, 1, 4, 0, 0, 1);
      repeat (3) step(R, 2, 1, 4, 0, 1, 1);
      repeat (2) step(R, 2, 1, 4, 0, 0, 1); nops(4);
      step(LW, 0, 2, 0, 0, 0, 1); step(R, 2, 1, 4, 0, 0, 1); step(R, 2, 1, 4, 0, 0, 0); nops(3);
      step(UND, 2, 3, 1, 0, 0, 1); step(J, 1, 2, 3, 0, 0, 1); nops(3);
      for (int n = 0; n < 3000; n++) begin
         logic [5:0] o;
         case ($urandom_range(0, 8))
            0: o = R;    1: o = LW;  2: o = SW;  3: o = ADDI; 4: o = BEQ;
            5: o = BNE;  6: o = J;   7: o = UND; default: o = 6'($urandom);
         endcase
         step(o, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0, $urandom_range(0, 49) != 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
